// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_instr_encoder
//  Purpose  : Encodes decoded RV32I instruction fields (class, registers,
//             funct fields, immediate) into 32-bit instruction words and
//             writes them sequentially into instruction memory through a
//             registered, back-pressured write port.
//  Optional : `define ENC_RANGE_CHECK_EN to flag immediates that do not fit
//             their instruction field (the word is still written, truncated).
//  Ports    : clk, rst_n            - clock / async active-low reset
//             start                 - pulse: (re)start a program load
//             in_valid/in_ready     - field bundle handshake
//             in_class..in_last     - instruction fields, end-of-program mark
//             wr_en/wr_ready        - memory write handshake
//             wr_addr/wr_data       - write byte address / encoded word
//             busy, done, err       - RUN state, DONE state, sticky error
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       c_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [31:0]        r_wr_data;
    logic               r_err;
    logic               r_last_pending;

    logic               w_in_xfer;
    logic               w_wr_xfer;
    logic               w_is_shift;
    logic               w_illegal;
    logic               w_range_bad;
    logic [31:0]        w_word;

    assign in_ready  = (r_state == S_RUN) && (!r_wr_en || wr_ready) && !r_last_pending;
    assign w_in_xfer = in_valid && in_ready;
    assign w_wr_xfer = r_wr_en && wr_ready;
    assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // ------------------------------------------------------------------
    // Field placement per instruction class
    // ------------------------------------------------------------------
    always_comb begin
        w_word    = c_NOP;
        w_illegal = 1'b0;
        case (in_class)
            4'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            4'd1: begin
                if (w_is_shift)
                    w_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                else
                    w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            4'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            4'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            4'd4: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            4'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
            4'd6: w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            4'd7: w_word = {in_imm[31:12], in_rd, 7'b0110111};
            4'd8: w_word = {in_imm[31:12], in_rd, 7'b0010111};
            default: begin
                w_word    = c_NOP;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A value fits an N-bit signed field when all bits above N-1 equal the
    // field's sign bit, i.e. the upper slice is all zeros or all ones.
    logic w_fit12;
    logic w_fitb;
    logic w_fitj;
    logic w_fitsh;

    assign w_fit12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign w_fitb  = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
    assign w_fitj  = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
    assign w_fitsh = !(|in_imm[31:5]);

    always_comb begin
        w_range_bad = 1'b0;
        case (in_class)
            4'd1:    w_range_bad = w_is_shift ? !w_fitsh : !w_fit12;
            4'd2,
            4'd3,
            4'd6:    w_range_bad = !w_fit12;
            4'd4:    w_range_bad = !w_fitb;
            4'd5:    w_range_bad = !w_fitj;
            default: w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (start)
                    w_state_next = S_RUN;
                else if (w_wr_xfer && r_last_pending)
                    w_state_next = S_DONE;
            end
            S_DONE:  if (start) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register, address counter, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en        <= 1'b0;
            r_wr_addr      <= c_BASE;
            r_wr_data      <= 32'h0;
            r_err          <= 1'b0;
            r_last_pending <= 1'b0;
        end else if (start) begin
            // Restart discards any word still waiting in the output register.
            r_wr_en        <= 1'b0;
            r_wr_addr      <= c_BASE;
            r_err          <= 1'b0;
            r_last_pending <= 1'b0;
        end else begin
            if (w_wr_xfer) begin
                r_wr_en   <= 1'b0;
                r_wr_addr <= r_wr_addr + ADDR_W'(4);
                // Only the final word can be in flight while last is pending.
                if (r_last_pending)
                    r_last_pending <= 1'b0;
            end
            if (w_in_xfer) begin
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word;
                r_err     <= r_err || w_illegal || w_range_bad;
                if (in_last)
                    r_last_pending <= 1'b1;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign err     = r_err;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire
